// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier command issuer.
// Holds the FSM state enum, the queued command record, and the parity helper.
package mult_pkg;

    localparam int MULT_DEPTH   = 4;
    localparam int MULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RDY
    } state_t;

    // One queued operand pair with its parity bits (34 bits total).
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        pa;
        logic        pb;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Even parity over a 16-bit operand.
    function automatic logic parity16(input logic [15:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mult_cmd_fifo.sv
// Synchronous FIFO of packed operand commands with first-word fall-through read.
// Ports: clk, rst_n, push/wdata, pop/rdata, full, empty.
module mult_cmd_fifo
    import mult_pkg::*;
#(
    parameter int DEPTH = MULT_DEPTH,
    parameter int WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leave occupancy unchanged.
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mult_cmd_issuer.sv
// Queues operand pairs with parity and issues them to a req/ack multiplier.
// Ports: in_* push side, m_* multiplier side, busy/issued_cnt/timeout_err status.
module mult_cmd_issuer
    import mult_pkg::*;
#(
    parameter int DEPTH   = MULT_DEPTH,
    parameter int TIMEOUT = MULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_a,
    input  logic signed [15:0] in_b,
    input  logic               in_corrupt_a,
    input  logic               in_corrupt_b,
    output logic signed [15:0] m_arg_a,
    output logic signed [15:0] m_arg_b,
    output logic               m_arg_a_parity,
    output logic               m_arg_b_parity,
    output logic               m_req,
    input  logic               m_ack,
    input  logic               m_result_rdy,
    output logic               busy,
    output logic [15:0]        issued_cnt,
    output logic               timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t     state;
    logic [TW-1:0] tcnt;

    cmd_t       wr_cmd;
    cmd_t       rd_cmd;
    logic [CMD_W-1:0] rd_bits;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       tmo_hit;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == ST_IDLE) && !empty;
    assign busy     = (state != ST_IDLE);
    assign tmo_hit  = (tcnt == TW'(TIMEOUT - 1));

    always_comb begin
        wr_cmd    = '0;
        wr_cmd.a  = in_a;
        wr_cmd.b  = in_b;
        wr_cmd.pa = parity16(in_a) ^ in_corrupt_a;
        wr_cmd.pb = parity16(in_b) ^ in_corrupt_b;
    end

    assign rd_cmd = cmd_t'(rd_bits);

    mult_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_cmd),
        .pop   (pop),
        .rdata (rd_bits),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            tcnt           <= '0;
            m_req          <= 1'b0;
            m_arg_a        <= '0;
            m_arg_b        <= '0;
            m_arg_a_parity <= 1'b0;
            m_arg_b_parity <= 1'b0;
            issued_cnt     <= '0;
            timeout_err    <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        m_arg_a        <= rd_cmd.a;
                        m_arg_b        <= rd_cmd.b;
                        m_arg_a_parity <= rd_cmd.pa;
                        m_arg_b_parity <= rd_cmd.pb;
                        m_req          <= 1'b1;
                        tcnt           <= '0;
                        state          <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    tcnt <= tcnt + 1'b1;
                    // A completion on the final cycle still counts as success.
                    if (m_ack && m_result_rdy) begin
                        m_req      <= 1'b0;
                        issued_cnt <= issued_cnt + 1'b1;
                        state      <= ST_IDLE;
                    end else if (m_ack) begin
                        m_req <= 1'b0;
                        state <= ST_WAIT_RDY;
                    end else if (tmo_hit) begin
                        m_req       <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_WAIT_RDY: begin
                    tcnt <= tcnt + 1'b1;
                    if (m_result_rdy) begin
                        issued_cnt <= issued_cnt + 1'b1;
                        state      <= ST_IDLE;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    m_req <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_cmd_issuer.sv
// Directed bench for mult_cmd_issuer: vector table plus multi-cycle sequences.
// Prints one summary line with the comparison and failure counts.
module tb_mult_cmd_issuer;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_a;
    logic signed [15:0] in_b;
    logic               in_corrupt_a;
    logic               in_corrupt_b;
    logic signed [15:0] m_arg_a;
    logic signed [15:0] m_arg_b;
    logic               m_arg_a_parity;
    logic               m_arg_b_parity;
    logic               m_req;
    logic               m_ack;
    logic               m_result_rdy;
    logic               busy;
    logic [15:0]        issued_cnt;
    logic               timeout_err;

    mult_cmd_issuer #(
        .DEPTH   (4),
        .TIMEOUT (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_corrupt_a   (in_corrupt_a),
        .in_corrupt_b   (in_corrupt_b),
        .m_arg_a        (m_arg_a),
        .m_arg_b        (m_arg_b),
        .m_arg_a_parity (m_arg_a_parity),
        .m_arg_b_parity (m_arg_b_parity),
        .m_req          (m_req),
        .m_ack          (m_ack),
        .m_result_rdy   (m_result_rdy),
        .busy           (busy),
        .issued_cnt     (issued_cnt),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] issue_log [$];
    int          req_cycles = 0;

    always @(posedge clk) begin
        if (m_req && m_ack) issue_log.push_back(m_arg_a);
        if (m_req) req_cycles++;
    end

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ca;
        logic        cb;
        logic        pa;
        logic        pb;
        logic        split;
    } vec_t;

    vec_t vt [6];

    logic [15:0] exp_issued;
    int          req_before;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{16'h0003, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[1] = '{16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{16'h7FFF, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[3] = '{16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[4] = '{16'hA5A5, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[5] = '{16'h1234, 16'h00F0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        in_corrupt_a = 1'b0;
        in_corrupt_b = 1'b0;
        m_ack        = 1'b0;
        m_result_rdy = 1'b0;
        exp_issued   = '0;
        repeat (3) tick();

        chk("rst_m_req", {15'd0, m_req}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_issued", issued_cnt, 16'd0);
        chk("rst_arg_a", m_arg_a, 16'd0);
        chk("rst_terr", {15'd0, timeout_err}, 16'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            in_valid     = 1'b1;
            in_a         = vt[i].a;
            in_b         = vt[i].b;
            in_corrupt_a = vt[i].ca;
            in_corrupt_b = vt[i].cb;
            tick();
            in_valid     = 1'b0;
            in_corrupt_a = 1'b0;
            in_corrupt_b = 1'b0;
            chk($sformatf("v%0d_req_lat0", i), {15'd0, m_req}, 16'd0);
            tick();
            chk($sformatf("v%0d_req", i), {15'd0, m_req}, 16'd1);
            chk($sformatf("v%0d_a", i), m_arg_a, vt[i].a);
            chk($sformatf("v%0d_b", i), m_arg_b, vt[i].b);
            chk($sformatf("v%0d_pa", i), {15'd0, m_arg_a_parity},
                {15'd0, vt[i].pa});
            chk($sformatf("v%0d_pb", i), {15'd0, m_arg_b_parity},
                {15'd0, vt[i].pb});
            if (vt[i].split) begin
                m_ack = 1'b1;
                tick();
                m_ack = 1'b0;
                chk($sformatf("v%0d_wait_req", i), {15'd0, m_req}, 16'd0);
                chk($sformatf("v%0d_wait_busy", i), {15'd0, busy}, 16'd1);
                chk($sformatf("v%0d_wait_a", i), m_arg_a, vt[i].a);
                m_result_rdy = 1'b1;
                tick();
                m_result_rdy = 1'b0;
            end else begin
                m_ack        = 1'b1;
                m_result_rdy = 1'b1;
                tick();
                m_ack        = 1'b0;
                m_result_rdy = 1'b0;
                chk($sformatf("v%0d_req_clr", i), {15'd0, m_req}, 16'd0);
            end
            exp_issued = exp_issued + 16'd1;
            chk($sformatf("v%0d_idle", i), {15'd0, busy}, 16'd0);
            chk($sformatf("v%0d_cnt", i), issued_cnt, exp_issued);
        end

        // Stalled multiplier: five pushes fit (one in flight, four queued).
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill%0d_ready", i), {15'd0, in_ready}, 16'd1);
            in_valid = 1'b1;
            in_a     = 16'(100 + i);
            in_b     = 16'(i);
            tick();
        end
        chk("fill_full", {15'd0, in_ready}, 16'd0);
        in_a = 16'd999;
        tick();
        chk("fill_still_full", {15'd0, in_ready}, 16'd0);
        chk("fill_inflight", m_arg_a, 16'd100);
        in_valid = 1'b0;
        issue_log.delete();
        m_ack        = 1'b1;
        m_result_rdy = 1'b1;
        repeat (12) tick();
        m_ack        = 1'b0;
        m_result_rdy = 1'b0;
        exp_issued = exp_issued + 16'd5;
        chk("drain_count", 16'(issue_log.size()), 16'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < issue_log.size())
                chk($sformatf("drain_order%0d", i), issue_log[i],
                    16'(100 + i));
        end
        chk("drain_cnt", issued_cnt, exp_issued);
        chk("drain_idle", {15'd0, busy}, 16'd0);
        chk("drain_ready", {15'd0, in_ready}, 16'd1);

        // No acknowledge at all: abort after 64 cycles in REQ.
        in_valid = 1'b1;
        in_a     = 16'h0055;
        in_b     = 16'h0066;
        tick();
        in_valid = 1'b0;
        tick();
        chk("tmo_req_start", {15'd0, m_req}, 16'd1);
        repeat (63) tick();
        chk("tmo_req_63", {15'd0, m_req}, 16'd1);
        chk("tmo_terr_63", {15'd0, timeout_err}, 16'd0);
        tick();
        chk("tmo_req_64", {15'd0, m_req}, 16'd0);
        chk("tmo_terr_64", {15'd0, timeout_err}, 16'd1);
        chk("tmo_busy", {15'd0, busy}, 16'd0);
        chk("tmo_cnt", issued_cnt, exp_issued);
        tick();
        chk("tmo_terr_pulse", {15'd0, timeout_err}, 16'd0);

        // Reset while waiting for the result with two entries queued.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 16'(200 + i);
            in_b     = 16'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("rw_inflight", m_arg_a, 16'd200);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("rw_wait_busy", {15'd0, busy}, 16'd1);
        chk("rw_wait_req", {15'd0, m_req}, 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_rst_busy", {15'd0, busy}, 16'd0);
        chk("rw_rst_cnt", issued_cnt, 16'd0);
        chk("rw_rst_a", m_arg_a, 16'd0);
        chk("rw_rst_b", m_arg_b, 16'd0);
        chk("rw_rst_pb", {15'd0, m_arg_b_parity}, 16'd0);
        chk("rw_rst_ready", {15'd0, in_ready}, 16'd1);
        tick();
        rst_n = 1'b1;
        req_before = req_cycles;
        repeat (10) tick();
        chk("rw_no_replay", 16'(req_cycles - req_before), 16'd0);
        chk("rw_idle", {15'd0, busy}, 16'd0);
        chk("rw_ready", {15'd0, in_ready}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
